// File: rtl/grid_scan_driver.sv
// Row-multiplexed 8x8 LED driver with a double-buffered grid and a generation pacing tick.
// Define GRID_SCAN_DIM_EN to add the 3-bit duty input that shortens the row drive within each dwell.
module grid_scan_driver #(
    parameter int ROW_CYCLES     = 1000,
    parameter int BLANK_CYCLES   = 4,
    parameter int FRAMES_PER_GEN = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
`ifdef GRID_SCAN_DIM_EN
    input  logic [2:0]  duty,
`endif
    input  logic [63:0] grid_in,
    input  logic        grid_valid,
    output logic        grid_ready,
    output logic [7:0]  row_sel,
    output logic [7:0]  col_data,
    output logic        frame_done,
    output logic        gen_tick
);

    localparam int DWELL_MAX = (ROW_CYCLES > BLANK_CYCLES) ? ROW_CYCLES : BLANK_CYCLES;
    localparam int DW = $clog2(DWELL_MAX);
    localparam int FW = (FRAMES_PER_GEN > 1) ? $clog2(FRAMES_PER_GEN) : 1;
    localparam logic [DW-1:0] ROW_LAST   = DW'(ROW_CYCLES - 1);
    localparam logic [DW-1:0] BLANK_LAST = DW'(BLANK_CYCLES - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_GEN - 1);

    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

    state_t          state_reg;
    logic [2:0]      row_reg;
    logic [DW-1:0]   dwell_reg;
    logic [FW-1:0]   frame_reg;
    logic [63:0]     pending_reg;
    logic [63:0]     shadow_reg;
    logic [31:0]     on_len;

    // Number of dwell cycles at the start of each row during which the row is lit.
`ifdef GRID_SCAN_DIM_EN
    assign on_len = (({29'd0, duty} + 32'd1) * 32'(ROW_CYCLES)) >> 3;
`else
    assign on_len = 32'(ROW_CYCLES);
`endif

    function automatic logic [7:0] row_drive(input logic [2:0] r, input logic [DW-1:0] d);
        row_drive = (32'(d) < on_len) ? (8'h01 << r) : 8'h00;
    endfunction

    // grid_ready doubles as the "pending empty" flag, so capture and swap never coincide.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            row_reg     <= 3'd0;
            dwell_reg   <= '0;
            frame_reg   <= '0;
            pending_reg <= 64'd0;
            shadow_reg  <= 64'd0;
            grid_ready  <= 1'b1;
            row_sel     <= 8'h00;
            col_data    <= 8'h00;
            frame_done  <= 1'b0;
            gen_tick    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            gen_tick   <= 1'b0;
            if (grid_valid && grid_ready) begin
                pending_reg <= grid_in;
                grid_ready  <= 1'b0;
            end
            if (!enable) begin
                state_reg <= IDLE;
                row_reg   <= 3'd0;
                dwell_reg <= '0;
                frame_reg <= '0;
                row_sel   <= 8'h00;
                col_data  <= 8'h00;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (!grid_ready) begin
                            shadow_reg <= pending_reg;
                            grid_ready <= 1'b1;
                        end
                        row_reg   <= 3'd0;
                        dwell_reg <= '0;
                        row_sel   <= 8'h00;
                        col_data  <= 8'h00;
                        state_reg <= BLANK;
                    end
                    BLANK: begin
                        if (dwell_reg == BLANK_LAST) begin
                            dwell_reg <= '0;
                            row_sel   <= row_drive(row_reg, '0);
                            col_data  <= shadow_reg[{row_reg, 3'b000} +: 8];
                            state_reg <= DRIVE;
                        end else begin
                            dwell_reg <= dwell_reg + 1'b1;
                        end
                    end
                    DRIVE: begin
                        if (dwell_reg == ROW_LAST) begin
                            dwell_reg <= '0;
                            row_sel   <= 8'h00;
                            col_data  <= 8'h00;
                            state_reg <= BLANK;
                            if (row_reg == 3'd7) begin
                                row_reg    <= 3'd0;
                                frame_done <= 1'b1;
                                if (!grid_ready) begin
                                    shadow_reg <= pending_reg;
                                    grid_ready <= 1'b1;
                                end
                                if (frame_reg == FRAME_LAST) begin
                                    gen_tick  <= 1'b1;
                                    frame_reg <= '0;
                                end else begin
                                    frame_reg <= frame_reg + 1'b1;
                                end
                            end else begin
                                row_reg <= row_reg + 3'd1;
                            end
                        end else begin
                            dwell_reg <= dwell_reg + 1'b1;
                            row_sel   <= row_drive(row_reg, dwell_reg + 1'b1);
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/grid_scan_driver.md
Name: grid_scan_driver

Overview:
- Downstream consumer of the 64-bit life grid produced by the iteration loop; drives an 8x8 LED matrix by row multiplexing.
- Double-buffers the grid: a pending register takes new generations via valid/ready; a shadow register holds the grid being displayed and updates only at a frame boundary, so no frame tears.
- Paces the simulation: emits a one-cycle gen_tick every FRAMES_PER_GEN frames to request the next iteration upstream.

Parameters:
- ROW_CYCLES, 1000, clock cycles each row is driven (>=2)
- BLANK_CYCLES, 4, all-off cycles before each row to prevent ghosting (>=1)
- FRAMES_PER_GEN, 30, full frames displayed per gen_tick (>=1)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- enable  input  1  display run enable
- grid_in  input  64  next grid; bit 8*r+c = row r, column c
- grid_valid  input  1  grid_in valid
- grid_ready  output  1  pending buffer empty; capture on valid&&ready
- row_sel  output  8  one-hot row drive, active-high
- col_data  output  8  column data for the driven row
- frame_done  output  1  one-cycle pulse at end of row 7
- gen_tick  output  1  one-cycle pulse requesting next generation

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, row=0, dwell/frame counters=0, shadow=0, pending empty, grid_ready=1, row_sel=0, col_data=0, frame_done=0, gen_tick=0. All outputs are registered.
- Capture: on a rising edge with grid_valid&&grid_ready, pending<=grid_in and grid_ready falls the next cycle. grid_ready rises the cycle after pending moves into shadow. No bypass: a grid captured in the swap cycle waits for the next swap.
- IDLE: row_sel=0, col_data=0. When enable=1, swap pending into shadow if full, set row=0, go to BLANK.
- BLANK: row_sel=0, col_data=0 for exactly BLANK_CYCLES cycles, then go to DRIVE.
- DRIVE: row_sel=8'h01<<row, col_data=shadow[8*row +: 8] for exactly ROW_CYCLES cycles. On the last cycle:
  - row<7: row++, go to BLANK.
  - row==7: frame_done=1 for one cycle; row=0; swap pending into shadow if full; frame_cnt++. If frame_cnt reaches FRAMES_PER_GEN-1, also pulse gen_tick for one cycle (same cycle as frame_done) and clear frame_cnt. Then go to BLANK.
- Frame length = 8*(BLANK_CYCLES+ROW_CYCLES) cycles.
- enable=0 in any state: next cycle IDLE, row_sel=0, col_data=0, row/dwell/frame counters cleared. Shadow and pending are kept. Capture still works in IDLE.
- Latency: a captured grid becomes visible at the start of the next frame, or on the IDLE-to-BLANK transition.
- Counters are sized by $clog2 of their parameter; no wrap beyond the terminal count.

Optional Feature:
- Macro GRID_SCAN_DIM_EN.
- Defined: adds input duty (3 bits). In DRIVE, row_sel is asserted only while dwell_cnt < ((duty+1)*ROW_CYCLES)>>3 and is 0 for the rest of the dwell. col_data is driven for the full dwell. Timing, frame_done and gen_tick are unchanged.
- Undefined: no duty port; row_sel is asserted for the full dwell.

Test Plan (ROW_CYCLES=4, BLANK_CYCLES=2, FRAMES_PER_GEN=2 unless noted):
- Load and display: with enable=0, present grid_in=64'h8040201008040201 with valid=1. Raise enable -> after 2 blank cycles row_sel=8'h01, col_data=8'h01 for 4 cycles; row r shows col_data=1<<r; grid_ready returns to 1.
- Frame timing and pacing: run continuously -> frame_done every 48 cycles; gen_tick every 96 cycles, coincident with every second frame_done.
- Backpressure and no-tear: mid-frame, capture grid A=64'hFF; hold grid B=64'h0 with valid=1 -> grid_ready=0 and B is not taken until A swaps in at frame_done. Row 0 shows 8'hFF only from the next frame on; B is captured the cycle after grid_ready rises.
- Enable drop: deassert enable during row 3 -> next cycle row_sel=0, col_data=0. Re-enable -> 2 blank cycles, then row_sel=8'h01 (restarts at row 0); frame_cnt restarted, so first gen_tick comes after 2 full frames.
- Async reset mid-drive: assert reset=0 between clock edges -> row_sel, col_data, frame_done and gen_tick go to 0 and grid_ready goes to 1 immediately; after release, the shadow displays all zeros.
- GRID_SCAN_DIM_EN, ROW_CYCLES=8, duty=3: row_sel is high for 4 of 8 dwell cycles; duty=7 gives 8 of 8; frame_done spacing stays 80 cycles.
